// File: rtl/enc_pkg.sv
// Shared types, read-kind constants and the velocity clamp used by the encoder sampler.
// The clamp works on a 64-bit sign-extended delta, so the caller's widths are not baked in.
package enc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } enc_state_t;

    localparam logic RD_POS = 1'b0;
    localparam logic RD_VEL = 1'b1;

    // Clamp d into the signed range of a vel_w-bit number.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] d,
                                                      input int vel_w);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (vel_w - 1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        if (d > max_v)
            return max_v;
        else if (d < min_v)
            return min_v;
        else
            return d;
    endfunction

endpackage

// File: rtl/enc_period_timer.sv
// Free-running sample period counter; emits a registered one-cycle wrap pulse.
// Dropping enable parks the count at zero so the next period starts fresh.
module enc_period_timer #(
    parameter int PERIOD = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic wrap
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (!enable) begin
                count <= '0;
            end else if (count == CW'(PERIOD - 1)) begin
                count <= '0;
                wrap  <= 1'b1;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/encoder_sample_scheduler.sv
// Periodic position/velocity sampler for NUM_ENC encoder counters with a single
// req/ack host read port that is held off while a scan is updating the banks.
module encoder_sample_scheduler
    import enc_pkg::*;
#(
    parameter int NUM_ENC = 2,
    parameter int CNT_W   = 32,
    parameter int VEL_W   = 16,
    parameter int PERIOD  = 50000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_ENC*CNT_W-1:0] enc_count,
    input  logic                     sample_en,
    input  logic                     rd_req,
    input  logic [2:0]               rd_sel,
    input  logic                     rd_kind,
    output logic                     rd_ack,
    output logic [31:0]              rd_data,
    output logic                     sample_tick,
    output logic [NUM_ENC-1:0]       vel_sat
);

    localparam int IDX_W = (NUM_ENC > 1) ? $clog2(NUM_ENC) : 1;

    logic             wrap;
    enc_state_t       state;
    logic [IDX_W-1:0] idx;
    logic             served;

    logic [CNT_W-1:0] pos_bank  [NUM_ENC];
    logic [CNT_W-1:0] prev_bank [NUM_ENC];
    logic [VEL_W-1:0] vel_bank  [NUM_ENC];
    logic [NUM_ENC-1:0] primed;

    logic [31:0] pos_ext [NUM_ENC];
    logic [31:0] vel_ext [NUM_ENC];

    logic [CNT_W-1:0]   cur_cnt;
    logic [CNT_W-1:0]   delta;
    logic signed [63:0] delta_ext;
    logic signed [63:0] delta_sat;
    logic               clamp;
    logic               read_ok;
    logic [31:0]        rd_value;
    logic [NUM_ENC-1:0] vel_set;
    logic [NUM_ENC-1:0] vel_clr;

    enc_period_timer #(
        .PERIOD(PERIOD)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (sample_en),
        .wrap   (wrap)
    );

    // Sign-extend (or truncate) each bank entry onto the 32-bit read bus.
    generate
        for (genvar gi = 0; gi < NUM_ENC; gi++) begin : g_ext
            assign pos_ext[gi] = 32'(signed'(pos_bank[gi]));
            assign vel_ext[gi] = 32'(signed'(vel_bank[gi]));
        end
    endgenerate

    // Modulo subtraction gives the right small delta across a counter wrap.
    always_comb begin
        cur_cnt   = enc_count[idx*CNT_W +: CNT_W];
        delta     = cur_cnt - prev_bank[idx];
        delta_ext = 64'(signed'(delta));
        delta_sat = sat_signed(delta_ext, VEL_W);
        clamp     = (delta_sat != delta_ext);
    end

    always_comb begin
        read_ok  = rd_req && !served && (state == IDLE || state == DONE);
        rd_value = '0;
        vel_set  = '0;
        vel_clr  = '0;
        for (int i = 0; i < NUM_ENC; i++) begin
            if (rd_sel == 3'(i))
                rd_value = (rd_kind == RD_VEL) ? vel_ext[i] : pos_ext[i];
            vel_clr[i] = read_ok && (rd_kind == RD_VEL) && (rd_sel == 3'(i));
            vel_set[i] = (state == SCAN) && (idx == IDX_W'(i)) && primed[i] && clamp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            served      <= 1'b0;
            rd_ack      <= 1'b0;
            rd_data     <= '0;
            sample_tick <= 1'b0;
            vel_sat     <= '0;
            primed      <= '0;
            for (int i = 0; i < NUM_ENC; i++) begin
                pos_bank[i]  <= '0;
                prev_bank[i] <= '0;
                vel_bank[i]  <= '0;
            end
        end else begin
            sample_tick <= 1'b0;
            rd_ack      <= 1'b0;
            // Set has priority over a same-cycle clear.
            vel_sat     <= (vel_sat & ~vel_clr) | vel_set;

            if (!rd_req) begin
                served <= 1'b0;
            end else if (read_ok) begin
                served  <= 1'b1;
                rd_ack  <= 1'b1;
                rd_data <= rd_value;
            end

            case (state)
                IDLE: begin
                    if (wrap) begin
                        state <= SCAN;
                        idx   <= '0;
                    end
                end
                SCAN: begin
                    pos_bank[idx]  <= cur_cnt;
                    prev_bank[idx] <= cur_cnt;
                    if (!primed[idx]) begin
                        vel_bank[idx] <= '0;
                        primed[idx]   <= 1'b1;
                    end else begin
                        vel_bank[idx] <= delta_sat[VEL_W-1:0];
                    end
                    if (idx == IDX_W'(NUM_ENC - 1)) begin
                        state       <= DONE;
                        sample_tick <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_encoder_sample_scheduler.sv
// Directed bench for encoder_sample_scheduler: per-period read tables plus
// hand-written sequences for the stalled read and the mid-scan reset.
module tb_encoder_sample_scheduler;

    localparam int NUM_ENC = 2;
    localparam int CNT_W   = 32;
    localparam int VEL_W   = 16;
    localparam int PERIOD  = 10;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_ENC*CNT_W-1:0] enc_count;
    logic                     sample_en;
    logic                     rd_req;
    logic [2:0]               rd_sel;
    logic                     rd_kind;
    logic                     rd_ack;
    logic [31:0]              rd_data;
    logic                     sample_tick;
    logic [NUM_ENC-1:0]       vel_sat;

    encoder_sample_scheduler #(
        .NUM_ENC(NUM_ENC),
        .CNT_W  (CNT_W),
        .VEL_W  (VEL_W),
        .PERIOD (PERIOD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enc_count  (enc_count),
        .sample_en  (sample_en),
        .rd_req     (rd_req),
        .rd_sel     (rd_sel),
        .rd_kind    (rd_kind),
        .rd_ack     (rd_ack),
        .rd_data    (rd_data),
        .sample_tick(sample_tick),
        .vel_sat    (vel_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         phase;
        logic [2:0] sel;
        logic       kind;
        logic [31:0] exp_data;
    } rd_vec_t;

    rd_vec_t     vecs [32];
    int          n_vecs = 0;
    logic [31:0] ph_cnt0 [7];
    logic [31:0] ph_cnt1 [7];
    logic [1:0]  ph_sat_before [7];
    logic [1:0]  ph_sat_after  [7];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end else begin
            $display("ok   %s: %h", name, got);
        end
    endtask

    task automatic add_vec(input int p, input logic [2:0] s, input logic k, input logic [31:0] e);
        vecs[n_vecs] = '{p, s, k, e};
        n_vecs++;
    endtask

    // Starts from a negedge with the timer parked at 0; tick is due 13 edges later.
    task automatic run_period(input string name);
        int tick_e;
        tick_e    = -1;
        sample_en = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (sample_tick) begin
                tick_e = e;
                break;
            end
        end
        sample_en = 1'b0;
        check({name, " tick_edge"}, 32'(tick_e), 32'd13);
        @(posedge clk);
        @(negedge clk);
        check({name, " tick_pulse"}, {31'd0, sample_tick}, 32'd0);
    endtask

    task automatic do_read(input string name, input logic [2:0] s, input logic k,
                           input logic [31:0] exp);
        int ack_e;
        logic [31:0] got;
        ack_e   = -1;
        got     = '0;
        rd_sel  = s;
        rd_kind = k;
        rd_req  = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (rd_ack) begin
                ack_e = e;
                got   = rd_data;
                if (k == 1'b1 && s < 3'(NUM_ENC))
                    check({name, " sat_clr_in_ack"}, {31'd0, vel_sat[s[0]]}, 32'd0);
                break;
            end
        end
        check({name, " ack_latency"}, 32'(ack_e), 32'd1);
        check({name, " data"}, got, exp);
        @(posedge clk);
        @(negedge clk);
        check({name, " held_req_no_ack"}, {31'd0, rd_ack}, 32'd0);
        rd_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_phase(input int p);
        string pname;
        pname     = $sformatf("P%0d", p);
        enc_count = {ph_cnt1[p], ph_cnt0[p]};
        run_period(pname);
        check({pname, " sat_before"}, {30'd0, vel_sat}, {30'd0, ph_sat_before[p]});
        for (int i = 0; i < n_vecs; i++) begin
            if (vecs[i].phase == p)
                do_read($sformatf("%s sel%0d kind%0d", pname, vecs[i].sel, vecs[i].kind),
                        vecs[i].sel, vecs[i].kind, vecs[i].exp_data);
        end
        check({pname, " sat_after"}, {30'd0, vel_sat}, {30'd0, ph_sat_after[p]});
    endtask

    initial begin
        int tick_e;
        int ack_e;
        int ack_cnt;
        logic [31:0] ack_data;

        ph_cnt0 = '{32'd100, 32'd107, 32'h7FFFFFFE, 32'h80000003, 32'h80000003, 32'h8000000F, 32'd5};
        ph_cnt1 = '{32'hFFFFFFFB, 32'hFFFFFFF8, 32'hFFFFFFF8, 32'hFFFFFFF8, 32'h00009C38, 32'hFFFF1598, 32'd6};
        ph_sat_before = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
        ph_sat_after  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00};

        add_vec(0, 3'd0, 1'b0, 32'd100);
        add_vec(0, 3'd1, 1'b0, 32'hFFFFFFFB);
        add_vec(0, 3'd0, 1'b1, 32'd0);
        add_vec(0, 3'd1, 1'b1, 32'd0);
        add_vec(0, 3'd5, 1'b0, 32'd0);
        add_vec(0, 3'd5, 1'b1, 32'd0);
        add_vec(1, 3'd0, 1'b1, 32'd7);
        add_vec(1, 3'd1, 1'b1, 32'hFFFFFFFD);
        add_vec(1, 3'd0, 1'b0, 32'd107);
        add_vec(1, 3'd1, 1'b0, 32'hFFFFFFF8);
        add_vec(2, 3'd0, 1'b1, 32'h00007FFF);
        add_vec(2, 3'd1, 1'b1, 32'd0);
        add_vec(2, 3'd0, 1'b0, 32'h7FFFFFFE);
        add_vec(3, 3'd0, 1'b1, 32'd5);
        add_vec(3, 3'd0, 1'b0, 32'h80000003);
        add_vec(4, 3'd1, 1'b1, 32'h00007FFF);
        add_vec(4, 3'd0, 1'b1, 32'd0);
        add_vec(4, 3'd1, 1'b0, 32'h00009C38);
        add_vec(5, 3'd0, 1'b1, 32'd0);
        add_vec(5, 3'd1, 1'b0, 32'hFFFF1598);
        add_vec(6, 3'd0, 1'b1, 32'd0);
        add_vec(6, 3'd1, 1'b1, 32'd0);
        add_vec(6, 3'd0, 1'b0, 32'd5);
        add_vec(6, 3'd1, 1'b0, 32'd6);

        rst_n     = 1'b0;
        sample_en = 1'b0;
        rd_req    = 1'b0;
        rd_sel    = '0;
        rd_kind   = 1'b0;
        enc_count = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset rd_ack", {31'd0, rd_ack}, 32'd0);
        check("reset rd_data", rd_data, 32'd0);
        check("reset sample_tick", {31'd0, sample_tick}, 32'd0);
        check("reset vel_sat", {30'd0, vel_sat}, 32'd0);
        rst_n = 1'b1;

        for (int p = 0; p <= 4; p++)
            do_phase(p);

        // Read raised on the first SCAN cycle must wait for DONE and see the new sample.
        enc_count = {ph_cnt1[4], 32'h8000000F};
        tick_e    = -1;
        ack_e     = -1;
        ack_cnt   = 0;
        ack_data  = '0;
        sample_en = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (rd_ack) begin
                ack_cnt++;
                if (ack_e < 0) begin
                    ack_e    = e;
                    ack_data = rd_data;
                end
            end
            if (sample_tick) begin
                tick_e    = e;
                sample_en = 1'b0;
            end
            if (e == 11) begin
                rd_sel  = 3'd0;
                rd_kind = 1'b0;
                rd_req  = 1'b1;
            end
        end
        rd_req = 1'b0;
        check("stall tick_edge", 32'(tick_e), 32'd13);
        check("stall ack_edge", 32'(ack_e), 32'd14);
        check("stall ack_count", 32'(ack_cnt), 32'd1);
        check("stall data", ack_data, 32'h8000000F);
        @(posedge clk);
        @(negedge clk);

        do_phase(5);

        // Reset in the middle of a scan clears outputs at once and unprimes the channels.
        sample_en = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n     = 1'b0;
        sample_en = 1'b0;
        #1;
        check("midrst rd_ack", {31'd0, rd_ack}, 32'd0);
        check("midrst rd_data", rd_data, 32'd0);
        check("midrst sample_tick", {31'd0, sample_tick}, 32'd0);
        check("midrst vel_sat", {30'd0, vel_sat}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        do_phase(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
